// File: rtl/turbo_ext_interleaver_if.sv
// Stream bundle for the extrinsic interleaver: symbol input side, permuted output side,
// hard decisions and block-done pulse. slave = interleaver view, master = driver view.
interface turbo_ext_interleaver_if #(
  parameter int DATA_W  = 10,
  parameter int SOFT_W  = 7,
  parameter int BLK_LEN = 7
);
  logic                     mode_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic signed [DATA_W-1:0] llr_i;
  logic signed [SOFT_W-1:0] sys_i;
  logic signed [SOFT_W-1:0] ext_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic signed [SOFT_W-1:0] out_data_o;
  logic [BLK_LEN-1:0]       hard_o;
  logic                     blk_done_o;

  modport slave (
    input  mode_i, in_valid_i, llr_i, sys_i, ext_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, hard_o, blk_done_o
  );

  modport master (
    output mode_i, in_valid_i, llr_i, sys_i, ext_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, hard_o, blk_done_o
  );
endinterface

// File: rtl/turbo_ext_interleaver.sv
// Scales/saturates SISO extrinsics into a flop buffer, then replays the block permuted.
// Written at the accepting edge; half-duplex, so input stalls for the whole drain phase.
module turbo_ext_interleaver #(
  parameter int DATA_W  = 10,
  parameter int SOFT_W  = 7,
  parameter int BLK_LEN = 7,
  parameter int P_STEP  = 3,
  parameter int P_OFF   = 0
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  turbo_ext_interleaver_if.slave bus
);
  localparam int CNT_W = $clog2(BLK_LEN);
  localparam int EW    = DATA_W + 2;

  localparam logic [CNT_W-1:0]     LAST   = CNT_W'(BLK_LEN - 1);
  localparam logic [CNT_W-1:0]     OFF    = CNT_W'(P_OFF);
  localparam logic [CNT_W:0]       STEP_E = (CNT_W + 1)'(P_STEP);
  localparam logic [CNT_W:0]       LEN_E  = (CNT_W + 1)'(BLK_LEN);
  localparam logic signed [EW-1:0] SAT_P  = EW'((2 ** (SOFT_W - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_N  = -SAT_P;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                   state_q;
  logic                     mode_q;
  logic                     blk_done_q;
  logic [CNT_W-1:0]         wr_cnt_q;
  logic [CNT_W-1:0]         rd_cnt_q;
  logic [CNT_W-1:0]         perm_q;
  logic [BLK_LEN-1:0]       hard_q;
  logic signed [SOFT_W-1:0] mem_q [BLK_LEN];

  logic [CNT_W:0]           perm_sum;
  logic [CNT_W-1:0]         perm_d;
  logic [CNT_W-1:0]         wr_addr;
  logic [CNT_W-1:0]         rd_addr;
  logic                     wr_mode;
  logic signed [EW-1:0]     diff;
  logic signed [EW-1:0]     scaled;
  logic signed [SOFT_W-1:0] ext_sat;

  // Next permutation index: one modular step, no multiplier.
  assign perm_sum = {1'b0, perm_q} + STEP_E;
  assign perm_d   = (perm_sum >= LEN_E) ? CNT_W'(perm_sum - LEN_E) : CNT_W'(perm_sum);

  // Symbol 0 must already use the incoming mode, before mode_q has captured it.
  assign wr_mode = (wr_cnt_q == '0) ? bus.mode_i : mode_q;
  assign wr_addr = wr_mode ? perm_q : wr_cnt_q;
  assign rd_addr = mode_q ? rd_cnt_q : perm_q;

  assign diff    = EW'(bus.llr_i) - EW'(bus.sys_i) - EW'(bus.ext_i);
  assign scaled  = diff - (diff >>> 2);
  assign ext_sat = (scaled > SAT_P) ? SOFT_W'(SAT_P) :
                   (scaled < SAT_N) ? SOFT_W'(SAT_N) : SOFT_W'(scaled);

  assign bus.in_ready_o  = (state_q == FILL);
  assign bus.out_valid_o = (state_q == DRAIN);
  assign bus.out_data_o  = (state_q == DRAIN) ? mem_q[rd_addr] : '0;
  assign bus.hard_o      = hard_q;
  assign bus.blk_done_o  = blk_done_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= FILL;
      mode_q     <= 1'b0;
      blk_done_q <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      perm_q     <= OFF;
      hard_q     <= '0;
      for (int i = 0; i < BLK_LEN; i++) mem_q[i] <= '0;
    end else begin
      blk_done_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (bus.in_valid_i) begin
            mem_q[wr_addr]   <= ext_sat;
            hard_q[wr_cnt_q] <= !bus.llr_i[DATA_W-1] && (bus.llr_i != '0);
            if (wr_cnt_q == '0) mode_q <= bus.mode_i;
            if (wr_cnt_q == LAST) begin
              wr_cnt_q <= '0;
              perm_q   <= OFF;
              state_q  <= DRAIN;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
              if (wr_mode) perm_q <= perm_d;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready_i) begin
            if (rd_cnt_q == LAST) begin
              rd_cnt_q   <= '0;
              perm_q     <= OFF;
              state_q    <= FILL;
              blk_done_q <= 1'b1;
            end else begin
              rd_cnt_q <= rd_cnt_q + CNT_W'(1);
              if (!mode_q) perm_q <= perm_d;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_turbo_ext_interleaver.sv
// Directed bench for turbo_ext_interleaver: block-level model plus literal expectations.
module tb_turbo_ext_interleaver;
  localparam int DATA_W  = 10;
  localparam int SOFT_W  = 7;
  localparam int BLK_LEN = 7;
  localparam int P_STEP  = 3;
  localparam int P_OFF   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  turbo_ext_interleaver_if #(.DATA_W(DATA_W), .SOFT_W(SOFT_W), .BLK_LEN(BLK_LEN)) bus ();

  turbo_ext_interleaver #(
    .DATA_W(DATA_W), .SOFT_W(SOFT_W), .BLK_LEN(BLK_LEN), .P_STEP(P_STEP), .P_OFF(P_OFF)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ext_model(input int llr, input int sys, input int ext);
    int d, q, s;
    d = llr - sys - ext;
    q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    s = d - q;
    if (s > 63) s = 63;
    if (s < -63) s = -63;
    return s;
  endfunction

  function automatic int perm(input int k);
    return (P_STEP * k + P_OFF) % BLK_LEN;
  endfunction

  // Block-level model state
  int                 exp_q[$];
  int                 cap_q[$];
  int                 done_times[$];
  int                 blk_s[BLK_LEN];
  int                 tmp_s[BLK_LEN];
  logic               blk_mode;
  int                 idx = 0;
  logic [BLK_LEN-1:0] exp_hard = '0;
  logic               done_exp = 1'b0;
  int                 out_cnt = 0;
  int                 dut_done_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      idx      = 0;
      exp_hard = '0;
      done_exp = 1'b0;
      out_cnt  = 0;
    end else begin
      chk("out_valid", bus.out_valid_o, exp_q.size() != 0);
      chk("in_ready", bus.in_ready_o, exp_q.size() == 0);
      chk("blk_done", bus.blk_done_o, done_exp);
      chk("hard", bus.hard_o, exp_hard);
      if (bus.out_valid_o && exp_q.size() != 0) chk("out_data", bus.out_data_o, exp_q[0]);
      else if (!bus.out_valid_o) chk("out_data_idle", bus.out_data_o, 0);
      if (bus.blk_done_o) begin
        dut_done_cnt++;
        done_times.push_back(cyc);
      end
      done_exp = 1'b0;
      if (bus.out_valid_o && bus.out_ready_i && exp_q.size() != 0) begin
        cap_q.push_back(int'(bus.out_data_o));
        void'(exp_q.pop_front());
        out_cnt++;
        if (exp_q.size() == 0) begin
          done_exp = 1'b1;
          out_cnt  = 0;
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (idx == 0) blk_mode = bus.mode_i;
        blk_s[idx]    = ext_model(int'(bus.llr_i), int'(bus.sys_i), int'(bus.ext_i));
        exp_hard[idx] = (bus.llr_i > 0);
        idx++;
        if (idx == BLK_LEN) begin
          idx = 0;
          for (int i = 0; i < BLK_LEN; i++) begin
            if (!blk_mode) exp_q.push_back(blk_s[perm(i)]);
            else tmp_s[perm(i)] = blk_s[i];
          end
          if (blk_mode) for (int i = 0; i < BLK_LEN; i++) exp_q.push_back(tmp_s[i]);
        end
      end
    end
  end

  // Output-ready driver: always ready, or random with a 5-cycle stall on the 3rd output.
  logic rdy_rand = 1'b0;
  int   stall_n  = 0;
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        if (out_cnt == 2 && stall_n < 5 && bus.out_valid_o) begin
          bus.out_ready_i = 1'b0;
          stall_n++;
        end else begin
          bus.out_ready_i = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.out_ready_i = 1'b1;
      end
    end
  end

  task automatic drive_sym(input int llr, input int sys, input int ext, input logic md);
    int   w = 0;
    logic acc = 1'b0;
    bus.llr_i      = DATA_W'(llr);
    bus.sys_i      = SOFT_W'(sys);
    bus.ext_i      = SOFT_W'(ext);
    bus.mode_i     = md;
    bus.in_valid_i = 1'b1;
    while (!acc && w < 200) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      @(posedge clk);
      #1;
      w++;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL in_accept_timeout: not accepted after %0d cycles, required within 200", w);
    end
  endtask

  task automatic send_block(input int llr[BLK_LEN], input int sys[BLK_LEN], input int ext[BLK_LEN],
                            input logic md0, input logic md1, input logic hold);
    for (int k = 0; k < BLK_LEN; k++) drive_sym(llr[k], sys[k], ext[k], (k < 3) ? md0 : md1);
    if (!hold) bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    while (cap_q.size() < n && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (cap_q.size() < n) begin
      n_chk++;
      $display("FAIL out_timeout: got %0d outputs, required %0d", cap_q.size(), n);
    end
    #1;
  endtask

  task automatic check_seq(input string name, input int exp[BLK_LEN], input int base);
    for (int i = 0; i < BLK_LEN; i++)
      chk($sformatf("%s[%0d]", name, i), (cap_q.size() > base + i) ? cap_q[base + i] : -999, exp[i]);
  endtask

  int ramp[BLK_LEN]    = '{0, 4, 8, 12, 16, 20, 24};
  int zeros[BLK_LEN]   = '{0, 0, 0, 0, 0, 0, 0};
  int seq_m0[BLK_LEN]  = '{0, 9, 18, 6, 15, 3, 12};
  int seq_m1[BLK_LEN]  = '{0, 15, 9, 3, 18, 12, 6};
  int c_llr[BLK_LEN]   = '{40, -5, -100, 511, 0, -512, 8};
  int c_sys[BLK_LEN]   = '{10, 0, 20, -64, 0, 63, 1};
  int c_ext[BLK_LEN]   = '{6, 0, 20, -64, 0, 63, 1};
  int seq_cor[BLK_LEN] = '{18, -63, 63, -3, 5, 0, -63};

  initial begin
    int dd0;
    bus.in_valid_i = 1'b0;
    bus.llr_i      = '0;
    bus.sys_i      = '0;
    bus.ext_i      = '0;
    bus.mode_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_data", bus.out_data_o, 0);
    chk("rst_hard", bus.hard_o, 0);
    chk("rst_blk_done", bus.blk_done_o, 0);
    @(posedge clk);
    #1;

    // Three accepts, then reset discards the partial block
    for (int k = 0; k < 3; k++) drive_sym(ramp[k], 0, 0, 1'b0);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("partial_hard", bus.hard_o, 7'b0000110);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_hard", bus.hard_o, 0);
    chk("midrst_in_ready", bus.in_ready_o, 1);
    @(posedge clk);
    #1;

    // Mode 0, ramp input
    cap_q.delete();
    dd0 = dut_done_cnt;
    send_block(ramp, zeros, zeros, 1'b0, 1'b0, 1'b0);
    wait_out(BLK_LEN);
    check_seq("m0", seq_m0, 0);
    chk("m0_hard", bus.hard_o, 7'b1111110);
    repeat (3) @(posedge clk);
    #1;
    chk("m0_done_pulses", dut_done_cnt - dd0, 1);

    // Mode 1, same input
    cap_q.delete();
    send_block(ramp, zeros, zeros, 1'b1, 1'b1, 1'b0);
    wait_out(BLK_LEN);
    check_seq("m1", seq_m1, 0);
    repeat (2) @(posedge clk);
    #1;

    // Arithmetic corners, mode 1
    cap_q.delete();
    send_block(c_llr, c_sys, c_ext, 1'b1, 1'b1, 1'b0);
    wait_out(BLK_LEN);
    check_seq("corner", seq_cor, 0);
    chk("corner_hard", bus.hard_o, 7'b1001001);
    repeat (2) @(posedge clk);
    #1;

    // Random backpressure with a long stall on the third output
    cap_q.delete();
    stall_n  = 0;
    rdy_rand = 1'b1;
    send_block(ramp, zeros, zeros, 1'b0, 1'b0, 1'b0);
    wait_out(BLK_LEN);
    rdy_rand = 1'b0;
    check_seq("bp", seq_m0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back blocks; mode_i flips mid-block and only affects the next block
    cap_q.delete();
    done_times.delete();
    send_block(ramp, zeros, zeros, 1'b0, 1'b1, 1'b1);
    send_block(ramp, zeros, zeros, 1'b1, 1'b0, 1'b1);
    send_block(ramp, zeros, zeros, 1'b0, 1'b0, 1'b0);
    wait_out(3 * BLK_LEN);
    check_seq("b2b_a", seq_m0, 0);
    check_seq("b2b_b", seq_m1, BLK_LEN);
    check_seq("b2b_c", seq_m0, 2 * BLK_LEN);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_done_count", done_times.size(), 3);
    if (done_times.size() >= 3) begin
      chk("b2b_period_ab", done_times[1] - done_times[0], 2 * BLK_LEN);
      chk("b2b_period_bc", done_times[2] - done_times[1], 2 * BLK_LEN);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
